// File: rtl/fx_pkg.sv
// Shared types and constants for the effect parameter controller.
// Parameter width, register map, reset defaults, FSM states and the slew helper.
package fx_pkg;

   localparam int unsigned PARAM_W    = 8;
   localparam int unsigned NUM_PARAMS = 4;

   typedef enum logic [1:0] {
      ADDR_THRESHOLD = 2'd0,
      ADDR_RATIO     = 2'd1,
      ADDR_ATTACK    = 2'd2,
      ADDR_RELEASE   = 2'd3
   } fx_addr_e;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      ARMED   = 2'd2,
      SLEW    = 2'd3
   } fx_state_e;

   localparam int unsigned DEF_THRESHOLD = 64;
   localparam int unsigned DEF_RATIO     = 4;
   localparam int unsigned DEF_ATTACK    = 32;
   localparam int unsigned DEF_RELEASE   = 32;

   function automatic int unsigned default_value(input int unsigned idx);
      case (idx)
         0:       return DEF_THRESHOLD;
         1:       return DEF_RATIO;
         2:       return DEF_ATTACK;
         default: return DEF_RELEASE;
      endcase
   endfunction

   // One bounded step of cur toward target; never overshoots, never wraps.
   function automatic int unsigned slew_toward(input int unsigned cur,
                                               input int unsigned target,
                                               input int unsigned step);
      int unsigned diff;
      if (target >= cur) begin
         diff = target - cur;
         return cur + ((diff < step) ? diff : step);
      end
      diff = cur - target;
      return cur - ((diff < step) ? diff : step);
   endfunction

endpackage

// File: rtl/fx_sample_tick.sv
// Sample-rate divider: one-cycle sample_en every SAMPLE_DIV clocks,
// raised in the cycle the count wraps from SAMPLE_DIV-1 back to 0.
module fx_sample_tick #(
   parameter int unsigned SAMPLE_DIV = 1042
) (
   input  logic clk,
   input  logic reset_n,
   output logic sample_en
);

   localparam int unsigned CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLE_DIV - 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         count     <= '0;
         sample_en <= 1'b0;
      end else begin
         sample_en <= (count == LAST);
         count     <= (count == LAST) ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/fx_param_ctrl.sv
// Effect parameter controller: host writes land in shadow registers and are
// applied to the live outputs on sample ticks after a commit.
// Build option FX_PARAM_SLEW_EN: slew live values by SLEW_STEP per tick
// instead of copying them in one tick.
module fx_param_ctrl
   import fx_pkg::*;
#(
   parameter int unsigned PARAM_W    = fx_pkg::PARAM_W,
   parameter int unsigned SAMPLE_DIV = 1042,
   parameter int unsigned SLEW_STEP  = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               wr_valid,
   output logic               wr_ready,
   input  logic [1:0]         wr_addr,
   input  logic [PARAM_W-1:0] wr_data,
   input  logic               commit,
   output logic               sample_en,
   output logic [PARAM_W-1:0] fx_threshold,
   output logic [PARAM_W-1:0] fx_ratio,
   output logic [PARAM_W-1:0] fx_attack,
   output logic [PARAM_W-1:0] fx_release,
   output logic               busy
);

   if (SLEW_STEP == 0) begin : g_step_check
      $error("fx_param_ctrl: SLEW_STEP must be nonzero");
   end

   fx_state_e          state;
   logic               dirty;
   logic [PARAM_W-1:0] live   [NUM_PARAMS];
   logic [PARAM_W-1:0] shadow [NUM_PARAMS];
   logic               accept;
   logic [PARAM_W-1:0] wr_value;

   fx_sample_tick #(
      .SAMPLE_DIV (SAMPLE_DIV)
   ) u_tick (
      .clk       (clk),
      .reset_n   (reset_n),
      .sample_en (sample_en)
   );

   // A zero ratio would disable the compressor; store 1 instead.
   always_comb begin
      accept   = wr_valid && wr_ready;
      wr_value = wr_data;
      if (wr_addr == ADDR_RATIO && wr_data == '0) begin
         wr_value = PARAM_W'(1);
      end
   end

`ifdef FX_PARAM_SLEW_EN
   logic [PARAM_W-1:0] stepped [NUM_PARAMS];
   logic               settled;

   always_comb begin
      settled = 1'b1;
      for (int unsigned i = 0; i < NUM_PARAMS; i++) begin
         stepped[i] = PARAM_W'(slew_toward(32'(live[i]), 32'(shadow[i]), SLEW_STEP));
         if (stepped[i] != shadow[i]) begin
            settled = 1'b0;
         end
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= IDLE;
         wr_ready <= 1'b0;
         busy     <= 1'b0;
         dirty    <= 1'b0;
         for (int unsigned i = 0; i < NUM_PARAMS; i++) begin
            live[i]   <= PARAM_W'(default_value(i));
            shadow[i] <= PARAM_W'(default_value(i));
         end
      end else begin
         if (accept) begin
            shadow[wr_addr] <= wr_value;
            dirty           <= 1'b1;
         end
         unique case (state)
            IDLE: begin
               wr_ready <= 1'b1;
               if (accept) begin
                  state <= PENDING;
                  busy  <= 1'b1;
               end
            end
            PENDING: begin
               // A write on the commit edge is already in shadow when ARMED samples it.
               if (commit && dirty) begin
                  state    <= ARMED;
                  wr_ready <= 1'b0;
               end
            end
            ARMED: begin
               if (sample_en) begin
`ifdef FX_PARAM_SLEW_EN
                  live <= stepped;
                  if (settled) begin
                     state    <= IDLE;
                     busy     <= 1'b0;
                     wr_ready <= 1'b1;
                     dirty    <= 1'b0;
                  end else begin
                     state <= SLEW;
                  end
`else
                  live     <= shadow;
                  state    <= IDLE;
                  busy     <= 1'b0;
                  wr_ready <= 1'b1;
                  dirty    <= 1'b0;
`endif
               end
            end
            SLEW: begin
`ifdef FX_PARAM_SLEW_EN
               if (sample_en) begin
                  live <= stepped;
                  if (settled) begin
                     state    <= IDLE;
                     busy     <= 1'b0;
                     wr_ready <= 1'b1;
                     dirty    <= 1'b0;
                  end
               end
`else
               state    <= IDLE;
               busy     <= 1'b0;
               wr_ready <= 1'b1;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign fx_threshold = live[ADDR_THRESHOLD];
   assign fx_ratio     = live[ADDR_RATIO];
   assign fx_attack    = live[ADDR_ATTACK];
   assign fx_release   = live[ADDR_RELEASE];

endmodule

// File: tb/tb_fx_param_ctrl.sv
// Bench for fx_param_ctrl: directed scenarios plus randomized write/commit
// traffic, checked every cycle against a cycle-level reference model.
module tb_fx_param_ctrl;
   import fx_pkg::*;

   localparam int DIV  = 10;
   localparam int STEP = 4;
`ifdef FX_PARAM_SLEW_EN
   localparam bit SLEW = 1'b1;
`else
   localparam bit SLEW = 1'b0;
`endif
   localparam int M_IDLE    = 0;
   localparam int M_PENDING = 1;
   localparam int M_ARMED   = 2;
   localparam int M_SLEW    = 3;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       wr_valid;
   logic       wr_ready;
   logic [1:0] wr_addr;
   logic [7:0] wr_data;
   logic       commit;
   logic       sample_en;
   logic [7:0] fx_threshold;
   logic [7:0] fx_ratio;
   logic [7:0] fx_attack;
   logic [7:0] fx_release;
   logic       busy;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: what the host has written, what the effect sees, and where
   // the commit handshake stands.
   int m_live   [4];
   int m_shadow [4];
   int m_phase;
   int m_edges;

   int    seen [$];
   int    exp_seq [3];
   int    prev;
   int    nw;
   int    a;
   int    d;
   int    ch_r;
   int    ch_rel;
   bit    cm;
   string pname [4] = '{"fx_threshold", "fx_ratio", "fx_attack", "fx_release"};

   always #5 clk = ~clk;

   fx_param_ctrl #(
      .PARAM_W    (8),
      .SAMPLE_DIV (DIV),
      .SLEW_STEP  (STEP)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .commit       (commit),
      .sample_en    (sample_en),
      .fx_threshold (fx_threshold),
      .fx_ratio     (fx_ratio),
      .fx_attack    (fx_attack),
      .fx_release   (fx_release),
      .busy         (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int live_out(input int i);
      case (i)
         0:       return int'(fx_threshold);
         1:       return int'(fx_ratio);
         2:       return int'(fx_attack);
         default: return int'(fx_release);
      endcase
   endfunction

   function automatic int toward(input int cur, input int tgt);
      if (tgt > cur) return cur + (((tgt - cur) < STEP) ? (tgt - cur) : STEP);
      return cur - (((cur - tgt) < STEP) ? (cur - tgt) : STEP);
   endfunction

   // Drive one cycle of inputs, advance the model across the edge, compare all outputs.
   task automatic step(input bit wv, input int addr, input int data, input bit cmt);
      bit pulse;
      bit ready;
      bit done;
      wr_valid = wv;
      wr_addr  = 2'(addr);
      wr_data  = 8'(data);
      commit   = cmt;
      pulse = (m_edges > 0) && (m_edges % DIV == 0);
      ready = (m_edges > 0) && (m_phase <= M_PENDING);
      if (wv && ready) m_shadow[addr] = (addr == 1 && data == 0) ? 1 : data;
      case (m_phase)
         M_IDLE:    if (wv && ready) m_phase = M_PENDING;
         M_PENDING: if (cmt) m_phase = M_ARMED;
         default: if (pulse) begin
            done = 1'b1;
            for (int i = 0; i < 4; i++) begin
               m_live[i] = SLEW ? toward(m_live[i], m_shadow[i]) : m_shadow[i];
               if (m_live[i] != m_shadow[i]) done = 1'b0;
            end
            m_phase = done ? M_IDLE : M_SLEW;
         end
      endcase
      @(posedge clk);
      #1;
      m_edges++;
      chk("sample_en", 32'(sample_en), 32'(m_edges % DIV == 0));
      chk("wr_ready", 32'(wr_ready), 32'(m_phase <= M_PENDING));
      chk("busy", 32'(busy), 32'(m_phase != M_IDLE));
      for (int i = 0; i < 4; i++) chk(pname[i], 32'(live_out(i)), 32'(m_live[i]));
   endtask

   task automatic do_reset();
      reset_n  = 1'b0;
      wr_valid = 1'b0;
      commit   = 1'b0;
      wr_addr  = 2'd0;
      wr_data  = 8'd0;
      @(posedge clk);
      #1;
      m_phase  = M_IDLE;
      m_edges  = 0;
      m_live   = '{64, 4, 32, 32};
      m_shadow = '{64, 4, 32, 32};
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_wr_ready", 32'(wr_ready), 32'd0);
      chk("rst_sample_en", 32'(sample_en), 32'd0);
      chk("rst_threshold", 32'(fx_threshold), 32'd64);
      chk("rst_ratio", 32'(fx_ratio), 32'd4);
      chk("rst_attack", 32'(fx_attack), 32'd32);
      chk("rst_release", 32'(fx_release), 32'd32);
      chk("rst_state", 32'(dut.state), 32'(IDLE));
      reset_n = 1'b1;
   endtask

   task automatic wait_idle(input int limit, input string tag);
      for (int k = 0; k < limit && m_phase != M_IDLE; k++) step(1'b0, 0, 0, 1'b0);
      chk(tag, 32'(busy), 32'd0);
   endtask

   initial begin
      reset_n  = 1'b0;
      wr_valid = 1'b0;
      commit   = 1'b0;
      wr_addr  = 2'd0;
      wr_data  = 8'd0;

      // Divider: pulses after edges 10, 20, 30 following reset release.
      do_reset();
      repeat (35) step(1'b0, 0, 0, 1'b0);

      // Uncommitted write stays in shadow.
      step(1'b1, 0, 200, 1'b0);
      repeat (50) step(1'b0, 0, 0, 1'b0);
      chk("pend_threshold", 32'(fx_threshold), 32'd64);
      chk("pend_busy", 32'(busy), 32'd1);
      chk("pend_state", 32'(dut.state), 32'(PENDING));

      // threshold 64 -> 76 after commit.
      do_reset();
      step(1'b0, 0, 0, 1'b0);
      step(1'b1, 0, 76, 1'b0);
      step(1'b0, 0, 0, 1'b1);
      seen.delete();
      prev = int'(fx_threshold);
      for (int k = 0; k < 200 && m_phase != M_IDLE; k++) begin
         step(1'b0, 0, 0, 1'b0);
         if (int'(fx_threshold) != prev) begin
            prev = int'(fx_threshold);
            seen.push_back(prev);
         end
      end
`ifdef FX_PARAM_SLEW_EN
      exp_seq = '{68, 72, 76};
      chk("slew_steps", 32'(seen.size()), 32'd3);
      for (int k = 0; k < 3; k++)
         chk("slew_value", 32'((k < seen.size()) ? seen[k] : -1), 32'(exp_seq[k]));
`else
      chk("copy_steps", 32'(seen.size()), 32'd1);
      chk("copy_value", 32'((seen.size() > 0) ? seen[0] : -1), 32'd76);
`endif
      chk("thr_done_busy", 32'(busy), 32'd0);

      // ratio and release committed together.
      do_reset();
      step(1'b0, 0, 0, 1'b0);
      step(1'b1, 1, 20, 1'b0);
      step(1'b1, 3, 8, 1'b1);
      ch_r   = -1;
      ch_rel = -1;
      for (int k = 0; k < 200 && m_phase != M_IDLE; k++) begin
         step(1'b0, 0, 0, 1'b0);
         if (ch_r < 0 && fx_ratio != 8'd4) ch_r = k;
         if (ch_rel < 0 && fx_release != 8'd32) ch_rel = k;
      end
`ifndef FX_PARAM_SLEW_EN
      chk("same_cycle", 32'(ch_r), 32'(ch_rel));
`endif
      chk("pair_ratio", 32'(fx_ratio), 32'd20);
      chk("pair_release", 32'(fx_release), 32'd8);

      // Ratio 0 clamps to 1; writes held while armed are refused.
      do_reset();
      step(1'b0, 0, 0, 1'b0);
      step(1'b1, 1, 0, 1'b0);
      step(1'b0, 0, 0, 1'b1);
      for (int k = 0; k < 200 && m_phase != M_IDLE; k++) step(1'b1, 1, 99, 1'b0);
      chk("clamp_ratio", 32'(fx_ratio), 32'd1);
      step(1'b1, 2, 33, 1'b0);
      step(1'b0, 0, 0, 1'b1);
      wait_idle(200, "attack_busy");
      chk("ratio_kept", 32'(fx_ratio), 32'd1);
      chk("attack_new", 32'(fx_attack), 32'd33);

      // Commit on a tick does not apply until the following tick.
      do_reset();
      step(1'b0, 0, 0, 1'b0);
      step(1'b1, 2, 50, 1'b0);
      for (int k = 0; k < 20 && !(m_edges % DIV == 0); k++) step(1'b0, 0, 0, 1'b0);
      chk("tick_align", 32'(sample_en), 32'd1);
      step(1'b0, 0, 0, 1'b1);
      chk("tick_commit_hold", 32'(fx_attack), 32'd32);
      wait_idle(300, "tick_busy");
      chk("tick_attack", 32'(fx_attack), 32'd50);

      // Reset mid-update.
      do_reset();
      step(1'b0, 0, 0, 1'b0);
      step(1'b1, 0, 200, 1'b0);
      step(1'b0, 0, 0, 1'b1);
      for (int k = 0; k < 100 && m_phase != (SLEW ? M_SLEW : M_ARMED); k++)
         step(1'b0, 0, 0, 1'b0);
      repeat (3) step(1'b0, 0, 0, 1'b0);
      chk("mid_busy", 32'(busy), 32'd1);
      do_reset();
      step(1'b0, 0, 0, 1'b0);
      chk("post_rst_state", 32'(dut.state), 32'(IDLE));
      chk("post_rst_threshold", 32'(fx_threshold), 32'd64);

      // Randomized write/commit traffic.
      for (int it = 0; it < 24; it++) begin
         if ($urandom_range(0, 3) == 0) step(1'b0, 0, 0, 1'b1);
         nw = int'($urandom_range(1, 3));
         for (int w = 0; w < nw; w++) begin
            a  = int'($urandom_range(0, 3));
            d  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
            cm = (w == nw - 1) && ($urandom_range(0, 1) == 1);
            step(1'b1, a, d, cm);
            repeat ($urandom_range(0, 2)) step(1'b0, 0, 0, 1'b0);
         end
         if (m_phase == M_PENDING) begin
            repeat ($urandom_range(0, 12)) step(1'b0, 0, 0, 1'b0);
            step(1'b0, 0, 0, 1'b1);
         end
         wait_idle(1000, "rand_busy");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
